mfp_adc_max10_arbiter: RTL

//  Shares the single MAX10 ADC sequencer command/response port between two ADC

---
 rtl/mfp_adc_max10_arbiter_pkg.sv | 24 ++
 rtl/mfp_adc_max10_arbiter_if.sv | 38 +++
 rtl/mfp_adc_owner_fifo.sv | 60 ++++++
 rtl/mfp_adc_max10_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/mfp_adc_max10_arbiter_pkg.sv
// Shared definitions for the MAX10 ADC sequencer arbiter.
//   - Stream widths for the command/response ports.
//   - Requester IDs stored in the owner FIFO.
//   - FSM state codes, which are also visible on the debug output.
package mfp_adc_max10_arbiter_pkg;

  localparam int CH_W   = 5;
  localparam int DATA_W = 12;

  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_GRANT0 = 2'b01,
    ARB_GRANT1 = 2'b10
  } arb_state_t;

  // Returns the grant state that belongs to a requester ID.
  function automatic arb_state_t grant_state(input logic id);
    return (id == ARB_M1) ? ARB_GRANT1 : ARB_GRANT0;
  endfunction

endpackage

// File: rtl/mfp_adc_max10_arbiter_if.sv
// One ADC sequencer style port: a command stream and a response stream.
//
// Handshake: a command beat transfers on a cycle where c_valid & c_ready are
// both 1. The sender holds the beat and its markers stable until that cycle.
// c_ready may depend combinationally on c_valid. The response stream has no
// ready: a beat transfers on every cycle where r_valid is 1.
//
// Modports:
//   master : drives the command stream and consumes responses (an ADC controller)
//   slave  : accepts commands and produces responses (the ADC sequencer side)
interface mfp_adc_max10_arbiter_if;
  import mfp_adc_max10_arbiter_pkg::*;

  logic              c_valid;
  logic [CH_W-1:0]   c_channel;
  logic              c_sop;
  logic              c_eop;
  logic              c_ready;

  logic              r_valid;
  logic [CH_W-1:0]   r_channel;
  logic [DATA_W-1:0] r_data;
  logic              r_sop;
  logic              r_eop;

  modport master (
    output c_valid, c_channel, c_sop, c_eop,
    input  c_ready,
    input  r_valid, r_channel, r_data, r_sop, r_eop
  );

  modport slave (
    input  c_valid, c_channel, c_sop, c_eop,
    output c_ready,
    output r_valid, r_channel, r_data, r_sop, r_eop
  );

endinterface

// File: rtl/mfp_adc_owner_fifo.sv
// Owner FIFO: remembers which requester issued each command packet whose
// response packet has not yet come back.
// Ports:
//   CLK, RESETn : clock, synchronous active-low reset (empties the FIFO)
//   push, din   : write requester ID din
//   pop         : drop the head entry
//   head        : ID at the head (meaningful only while !empty)
//   empty, full : occupancy flags
module mfp_adc_owner_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic CLK,
  input  logic RESETn,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic head,
  output logic empty,
  output logic full
);

  logic          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO is only honoured when the head leaves in the
  // same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; entries are only read while count says valid.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/mfp_adc_max10_arbiter.sv
// Shares one MAX10 ADC sequencer command/response port between two ADC
// controllers. Command packets (SOP..EOP) are granted whole, round-robin on
// ties; the issuer of each packet is queued and the matching response packet
// is routed back to it.
// Ports:
//   CLK, RESETn : clock, synchronous active-low reset
//   m0, m1      : requester ports (slave side: commands in, responses out)
//   adc         : ADC sequencer port (master side: commands out, responses in)
//   ErrClear    : clears RespErr
//   Busy        : a grant is held or responses are still owed
//   RespErr     : sticky, a response beat arrived with no recorded owner
//   state_dbg   : current FSM state code
module mfp_adc_max10_arbiter
  import mfp_adc_max10_arbiter_pkg::*;
#(
  parameter int OWNER_DEPTH = 4,
  parameter int OWNER_AW    = 2
) (
  input  logic                    CLK,
  input  logic                    RESETn,
  mfp_adc_max10_arbiter_if.slave  m0,
  mfp_adc_max10_arbiter_if.slave  m1,
  mfp_adc_max10_arbiter_if.master adc,
  input  logic                    ErrClear,
  output logic                    Busy,
  output logic                    RespErr,
  output logic [1:0]              state_dbg
);

  arb_state_t state;
  logic       last_gnt;
  logic       req0;
  logic       req1;
  logic       pick;
  logic       cmd_fire;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_head;
  logic       fifo_empty;
  logic       fifo_full;

  // Only a packet start counts as a request, so a stray mid-packet beat can
  // never win the port.
  assign req0 = m0.c_valid & m0.c_sop;
  assign req1 = m1.c_valid & m1.c_sop;

  // On a tie the requester that did not win last time goes next.
  assign pick = (req0 & req1) ? ~last_gnt : req1;

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state    <= ARB_IDLE;
      last_gnt <= ARB_M1;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (!fifo_full && (req0 || req1)) begin
            state    <= grant_state(pick);
            last_gnt <= pick;
          end
        end
        ARB_GRANT0, ARB_GRANT1: begin
          // Returning through IDLE gives the one-cycle gap between packets.
          if (cmd_fire && adc.c_eop) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Command mux. Everything is forced low while reset is asserted because the
  // reset itself only takes effect at the next clock edge.
  always_comb begin
    adc.c_valid   = 1'b0;
    adc.c_channel = '0;
    adc.c_sop     = 1'b0;
    adc.c_eop     = 1'b0;
    m0.c_ready    = 1'b0;
    m1.c_ready    = 1'b0;
    if (RESETn) begin
      case (state)
        ARB_GRANT0: begin
          adc.c_valid   = m0.c_valid;
          adc.c_channel = m0.c_channel;
          adc.c_sop     = m0.c_sop;
          adc.c_eop     = m0.c_eop;
          m0.c_ready    = adc.c_ready;
        end
        ARB_GRANT1: begin
          adc.c_valid   = m1.c_valid;
          adc.c_channel = m1.c_channel;
          adc.c_sop     = m1.c_sop;
          adc.c_eop     = m1.c_eop;
          m1.c_ready    = adc.c_ready;
        end
        default: ;
      endcase
    end
  end

  assign cmd_fire  = adc.c_valid & adc.c_ready;
  assign fifo_push = cmd_fire & adc.c_sop;
  assign fifo_pop  = RESETn & adc.r_valid & adc.r_eop & ~fifo_empty;

  mfp_adc_owner_fifo #(
    .DEPTH (OWNER_DEPTH),
    .AW    (OWNER_AW)
  ) u_owner_fifo (
    .CLK    (CLK),
    .RESETn (RESETn),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .din    (state == ARB_GRANT1),
    .head   (fifo_head),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  // Response demux: payload is broadcast, only the valid is steered.
  assign m0.r_valid   = RESETn & adc.r_valid & ~fifo_empty & (fifo_head == ARB_M0);
  assign m1.r_valid   = RESETn & adc.r_valid & ~fifo_empty & (fifo_head == ARB_M1);
  assign m0.r_channel = adc.r_channel;
  assign m0.r_data    = adc.r_data;
  assign m0.r_sop     = adc.r_sop;
  assign m0.r_eop     = adc.r_eop;
  assign m1.r_channel = adc.r_channel;
  assign m1.r_data    = adc.r_data;
  assign m1.r_sop     = adc.r_sop;
  assign m1.r_eop     = adc.r_eop;

  // Orphan response beats are dropped and flagged; a new error outranks a
  // clear arriving in the same cycle.
  always_ff @(posedge CLK) begin
    if (!RESETn)                        RespErr <= 1'b0;
    else if (adc.r_valid && fifo_empty) RespErr <= 1'b1;
    else if (ErrClear)                  RespErr <= 1'b0;
  end

  assign Busy      = (state != ARB_IDLE) | ~fifo_empty;
  assign state_dbg = state;

endmodule
